pci_reg_arbiter: RTL

- Shares one single-port register bank between two requesters: the PCI target's IO/MEM window (PCI side) and the CNC motion core (local side).
- One access per clock.
- PCI side has fixed priority. A streak counter bounds local-side starvation.
- Per-word doorbell flags tell the local core which words the host has written.

---
 rtl/pci_reg_arbiter.sv | 114 +++++++++++
 1 files changed

// File: rtl/pci_reg_arbiter.sv
// rtl/pci_reg_arbiter.sv - PCI/local shared register bank with fixed-priority arbitration and doorbells
// PCI wins ties until it has taken MAX_PCI_STREAK grants in a row over a waiting local request.
module pci_reg_arbiter #(
  parameter int ADDR_BITS      = 2,
  parameter int MAX_PCI_STREAK = 4
) (
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic                      PCI_REQ,
  input  logic                      PCI_WE,
  input  logic [ADDR_BITS-1:0]      PCI_ADDR,
  input  logic [31:0]               PCI_WDATA,
  input  logic [3:0]                PCI_BE_N,
  output logic                      PCI_GNT,
  output logic                      PCI_RVALID,
  output logic [31:0]               PCI_RDATA,
  input  logic                      LOC_REQ,
  input  logic                      LOC_WE,
  input  logic [ADDR_BITS-1:0]      LOC_ADDR,
  input  logic [31:0]               LOC_WDATA,
  input  logic [3:0]                LOC_BE,
  output logic                      LOC_GNT,
  output logic                      LOC_RVALID,
  output logic [31:0]               LOC_RDATA,
  input  logic [(1<<ADDR_BITS)-1:0] LOC_ACK,
  output logic [(1<<ADDR_BITS)-1:0] DOORBELL,
  output logic                      DOORBELL_ANY
);

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] MAX_CNT = 4'(MAX_PCI_STREAK);

  logic [31:0]          r_bank [DEPTH];
  logic [3:0]           r_cnt;
  logic [DEPTH-1:0]     r_doorbell;
  logic [31:0]          r_pci_rdata;
  logic [31:0]          r_loc_rdata;
  logic                 r_pci_rvalid;
  logic                 r_loc_rvalid;

  logic                 w_pci_gnt;
  logic                 w_loc_gnt;
  logic                 w_we;
  logic [ADDR_BITS-1:0] w_addr;
  logic [31:0]          w_wdata;
  logic [3:0]           w_be;
  logic [DEPTH-1:0]     w_db_set;
  logic [DEPTH-1:0]     w_one;

  // Grants are gated by RST_N so nothing is granted while reset is held.
  assign w_pci_gnt = RST_N & PCI_REQ & (~LOC_REQ | (r_cnt < MAX_CNT));
  assign w_loc_gnt = RST_N & LOC_REQ & (~PCI_REQ | (r_cnt >= MAX_CNT));

  assign w_we    = (w_pci_gnt & PCI_WE) | (w_loc_gnt & LOC_WE);
  assign w_addr  = w_pci_gnt ? PCI_ADDR  : LOC_ADDR;
  assign w_wdata = w_pci_gnt ? PCI_WDATA : LOC_WDATA;
  assign w_be    = w_pci_gnt ? ~PCI_BE_N : LOC_BE;

  assign w_one    = {{(DEPTH-1){1'b0}}, 1'b1};
  assign w_db_set = (w_pci_gnt & PCI_WE & ~(&PCI_BE_N)) ? (w_one << PCI_ADDR) : '0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (!LOC_REQ || w_loc_gnt) begin
      r_cnt <= '0;
    end else if (w_pci_gnt && (r_cnt < MAX_CNT)) begin
      r_cnt <= r_cnt + 4'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) r_bank[i] <= '0;
    end else if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_bank[w_addr][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pci_rdata  <= '0;
      r_loc_rdata  <= '0;
      r_pci_rvalid <= 1'b0;
      r_loc_rvalid <= 1'b0;
    end else begin
      r_pci_rvalid <= w_pci_gnt & ~PCI_WE;
      r_loc_rvalid <= w_loc_gnt & ~LOC_WE;
      if (w_pci_gnt && !PCI_WE) r_pci_rdata <= r_bank[PCI_ADDR];
      if (w_loc_gnt && !LOC_WE) r_loc_rdata <= r_bank[LOC_ADDR];
    end
  end

  // Set is applied after clear so a same-cycle set/ack leaves the bit set.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_doorbell <= '0;
    end else begin
      r_doorbell <= (r_doorbell & ~LOC_ACK) | w_db_set;
    end
  end

  assign PCI_GNT      = w_pci_gnt;
  assign LOC_GNT      = w_loc_gnt;
  assign PCI_RVALID   = r_pci_rvalid;
  assign PCI_RDATA    = r_pci_rdata;
  assign LOC_RVALID   = r_loc_rvalid;
  assign LOC_RDATA    = r_loc_rdata;
  assign DOORBELL     = r_doorbell;
  assign DOORBELL_ANY = |r_doorbell;

endmodule
